demux16_deser: RTL
==================

// Module: demux16_deser
// PURPOSE
//  Serial-to-parallel 1:16 demultiplexer: the receive-side counterpart of the 16:1 bit-select mux.
//  Accepts one bit per valid/ready handshake and steers the k-th accepted bit into output slot k.
//  After 16 bits, presents the assembled word on a valid/ready output port.
//  Sits between a serial bit source (e.g. a mux16to1 scanned with sel=0..15) and word-wide logic.
// PARAMETERS
//  WIDTH      16  word width / number of demux slots; pointer width is $clog2(WIDTH) (4 at default)
//  MSB_FIRST  0   0: k-th accepted bit -> data_out[k]; 1: k-th accepted bit -> data_out[WIDTH-1-k]
// PORTS
//  clk         in   1      clock; all state updates on its rising edge
//  rst         in   1      synchronous, active-high reset
//  en          in   1      block enable; 0 pauses input acceptance; partial word is kept
//  din         in   1      serial data bit
//  din_valid   in   1      din is valid this cycle
//  din_ready   out  1      block accepts din this cycle (comb: state==FILL && en && !rst)
//  data_out    out  WIDTH  assembled word; meaningful only while out_valid=1
//  out_valid   out  1      data_out holds a complete word
//  out_ready   in   1      consumer takes the word this cycle
//  sel_out     out  4      slot index that the next accepted bit writes (demux select)
//  parity_err  out  1      only with DEMUX_PARITY_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (rst=1 at edge): state=FILL, data_out=0, out_valid=0, sel_out=0, bit count=0, parity_err=0.
//  din_ready is 0 whenever rst=1.
//  Accept = din_valid && din_ready. A bit is written only on accept. No other event writes data_out.
//  FSM:
//   FILL: on accept, write din to slot sel_out (after MSB_FIRST mapping); sel_out++, count++.
//    On the accept that makes count==WIDTH, next state is HOLD and out_valid=1 on the following cycle.
//    Latency: 1 cycle from the last accept to out_valid.
//   HOLD: din_ready=0, and data_out/out_valid are stable. On out_ready=1: next cycle out_valid=0,
//    data_out=0, count=0, sel_out=0, state=FILL.
//    No accept can occur in the same cycle as the hand-off.
//  en=0 in FILL: no accept; count/sel_out/partial data held; resumes from the same slot when en=1.
//  en does not gate the output side: HOLD drains on out_ready regardless of en.
//  sel_out wraps 15->0 only via the HOLD->FILL transition. Never increments past WIDTH-1.
//  out_ready while out_valid=0: ignored.
//  rst mid-word or in HOLD: the partial or held word is discarded; all state returns to reset values.
// CONFIGURATION
//  DEMUX_PARITY_EN defined:
//   - FILL accepts WIDTH+1 bits; the extra bit is even parity over the WIDTH data bits and is not stored.
//   - The HOLD transition occurs on the parity-bit accept.
//   - parity_err = 1 in HOLD when XOR of the data bits and the parity bit is 1. It is valid with
//     out_valid and cleared with it.
//  DEMUX_PARITY_EN undefined: no parity_err port; exactly WIDTH bits per word.
// TESTING
//  1 Reset: rst=1 for 2 clk with din_valid=1 -> data_out=0, out_valid=0, sel_out=0, din_ready=0;
//    din_ready=1 after rst drops (en=1).
//  2 Disabled: en=0, din_valid=1, din toggling, 20 clk -> no accept, sel_out=0, out_valid=0.
//  3 LSB-first word: en=1, 16 back-to-back bits of 16'hA5C3 (bit0 first) -> out_valid one clk after
//    the 16th accept, data_out=16'hA5C3. With MSB_FIRST=1, same stream -> 16'hC3A5 bit-reversed (16'hC3A5).
//  4 Backpressure: complete word with out_ready=0 for 5 clk -> data_out/out_valid stable, din_ready=0;
//    out_ready=1 -> next clk out_valid=0, sel_out=0, din_ready=1.
//  5 Pause/resume: send 7 bits of 16'h1234, en=0 for 3 clk (sel_out=7 held), resend remaining 9 ->
//    data_out=16'h1234. Also rst after 9 bits -> all state cleared, next word 16'hFFFF assembles correctly.
//  6 Parity (macro on): 16'h0001 + parity bit 1 -> parity_err=0; 16'h0001 + parity bit 0 -> parity_err=1.
//    Both yield data_out=16'h0001.

Source files
------------

// File: rtl/demux16_deser.sv
// rtl/demux16_deser.sv - serial-to-parallel 1:WIDTH bit demultiplexer with valid/ready ports
//
// Purpose:
//   Accepts one serial bit per din handshake. The k-th accepted bit is steered into word slot k,
//   or into slot WIDTH-1-k when MSB_FIRST=1. The completed word is then offered on a valid/ready
//   output port. The block holds that word until the consumer takes it.
//   Optional feature macro: DEMUX_PARITY_EN. When it is defined, each word carries one extra
//   even-parity bit. That bit is checked and not stored, and the result is reported on o_parity_err.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_en           input-side enable; 0 pauses acceptance and keeps the partial word
//   i_din          serial data bit
//   i_din_valid    i_din is valid this cycle
//   o_din_ready    bit is accepted this cycle (FILL && en && !rst)
//   o_data_out     assembled word, meaningful while o_out_valid=1
//   o_out_valid    o_data_out holds a complete word
//   i_out_ready    consumer takes the word this cycle
//   o_sel_out      slot index that the next accepted bit writes
//   o_parity_err   (DEMUX_PARITY_EN only) parity mismatch flag, valid with o_out_valid

module demux16_deser #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_din,
    input  logic                     i_din_valid,
    output logic                     o_din_ready,
    output logic [WIDTH-1:0]         o_data_out,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
`ifdef DEMUX_PARITY_EN
    output logic                     o_parity_err,
`endif
    output logic [$clog2(WIDTH)-1:0] o_sel_out
);

    localparam int PW = $clog2(WIDTH);
`ifdef DEMUX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [PW-1:0]    r_sel;
    logic [CW-1:0]    r_count;
    logic             w_din_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_handoff;
    logic             w_is_data;
    logic [PW-1:0]    w_slot;
`ifdef DEMUX_PARITY_EN
    logic             r_parity_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_din_ready  = 1'b0;
        w_accept     = 1'b0;
        w_handoff    = 1'b0;
        w_last       = (r_count == CW'(NBITS - 1));
        case (r_state)
            FILL: begin
                w_din_ready = i_en && !i_rst;
                w_accept    = w_din_ready && i_din_valid;
                if (w_accept && w_last) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_handoff = i_out_ready;
                if (w_handoff) begin
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    // With parity enabled, the final accepted bit is the parity bit. It must not overwrite a data slot.
    assign w_is_data = (r_count < CW'(WIDTH));
    assign w_slot    = MSB_FIRST ? (PW'(WIDTH - 1) - r_sel) : r_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_count <= '0;
        end else if (w_handoff) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            if (w_is_data) begin
                r_data[w_slot] <= i_din;
            end
            r_count <= r_count + 1'b1;
            // sel_out stops at the last slot; only the HOLD->FILL hand-off returns it to 0.
            if (r_sel != PW'(WIDTH - 1)) begin
                r_sel <= r_sel + 1'b1;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    // Even parity: the XOR of all data bits and the parity bit must be 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_handoff) begin
            r_parity_err <= 1'b0;
        end else if (w_accept && w_last) begin
            r_parity_err <= (^r_data) ^ i_din;
        end
    end

    assign o_parity_err = r_parity_err;
`endif

    assign o_din_ready = w_din_ready;
    assign o_data_out  = r_data;
    assign o_out_valid = (r_state == HOLD);
    assign o_sel_out   = r_sel;

endmodule
